// File: rtl/rv32i_mmio_timer.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_mmio_timer
//  Description : Memory-mapped prescaled timer on the RV32I data port.
//                Registers: CTRL(0x0), COUNT(0x4), CMP(0x8), STATUS(0xC).
//                Periodic / one-shot compare match with sticky W1C status.
//                Optional macro TIMER_IRQ_EN implements CTRL.IE and drives
//                irq = MATCH & IE; when undefined irq is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32i_mmio_timer #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0100,
    parameter int          PRESCALE_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwdata,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_off_ctrl  = 2'd0;
    localparam logic [1:0] c_off_count = 2'd1;
    localparam logic [1:0] c_off_cmp   = 2'd2;
    localparam logic [1:0] c_off_stat  = 2'd3;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_en;
    logic                  r_mode;
    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] r_pre_cnt;
    logic [31:0]           r_count;
    logic [31:0]           r_cmp;
    logic                  r_match;
    logic                  r_ie;

    logic w_valid;
    logic w_wr;
    logic w_wr_ctrl;
    logic w_wr_count;
    logic w_wr_cmp;
    logic w_wr_stat;
    logic w_tick;
    logic w_hit;
    logic w_oneshot_done;

    // Address decode: only word-aligned offsets inside the 16-byte window respond
    assign sel        = (memaddr[31:4] == BASE_ADDR[31:4]);
    assign w_valid    = sel && (memaddr[1:0] == 2'b00);
    assign w_wr       = memwrite && w_valid;
    assign w_wr_ctrl  = w_wr && (memaddr[3:2] == c_off_ctrl);
    assign w_wr_count = w_wr && (memaddr[3:2] == c_off_count);
    assign w_wr_cmp   = w_wr && (memaddr[3:2] == c_off_cmp);
    assign w_wr_stat  = w_wr && (memaddr[3:2] == c_off_stat);

    // A tick is the prescaler wrapping while running; a hit is a tick on COUNT==CMP
    assign w_tick         = (r_state == ST_RUN) && (r_pre_cnt == r_pre);
    assign w_hit          = w_tick && (r_count == r_cmp);
    assign w_oneshot_done = w_hit && r_mode;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a software CTRL write always overrides the hardware one-shot stop
    always_comb begin
        w_state_nxt = r_state;
        if (w_wr_ctrl) begin
            w_state_nxt = memwdata[0] ? ST_RUN : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (r_en) w_state_nxt = ST_RUN;
                ST_RUN:  if (w_oneshot_done) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_DONE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Control, prescaler, counter, compare and sticky match registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_en      <= 1'b0;
            r_mode    <= 1'b0;
            r_pre     <= '0;
            r_pre_cnt <= '0;
            r_count   <= 32'd0;
            r_cmp     <= 32'hFFFF_FFFF;
            r_match   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en   <= memwdata[0];
                r_mode <= memwdata[1];
                r_pre  <= memwdata[8 +: PRESCALE_W];
            end else if (w_oneshot_done) begin
                r_en <= 1'b0;
            end

            // Prescaler only advances while running now and in the next cycle
            if ((r_state != ST_RUN) || (w_state_nxt != ST_RUN) || w_tick) begin
                r_pre_cnt <= '0;
            end else begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end

            // Software write beats the tick; a one-shot hit leaves COUNT at CMP
            if (w_wr_count) begin
                r_count <= memwdata;
            end else if (w_tick) begin
                if (w_hit) begin
                    if (!r_mode) begin
                        r_count <= 32'd0;
                    end
                end else begin
                    r_count <= r_count + 32'd1;
                end
            end

            if (w_wr_cmp) begin
                r_cmp <= memwdata;
            end

            // Set has priority over write-1-to-clear
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_stat && memwdata[0]) begin
                r_match <= 1'b0;
            end
        end
    end

`ifdef TIMER_IRQ_EN
    // Interrupt enable bit lives in CTRL[2]
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ie <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_ie <= memwdata[2];
        end
    end

    assign irq = r_match && r_ie;
`else
    assign r_ie = 1'b0;
    assign irq  = 1'b0;
`endif

    // Combinational read mux, zero outside the window or on unused offsets
    always_comb begin
        rdata = 32'd0;
        if (w_valid) begin
            case (memaddr[3:2])
                c_off_ctrl: begin
                    rdata[0]              = r_en;
                    rdata[1]              = r_mode;
                    rdata[2]              = r_ie;
                    rdata[8 +: PRESCALE_W] = r_pre;
                end
                c_off_count: rdata = r_count;
                c_off_cmp:   rdata = r_cmp;
                c_off_stat: begin
                    rdata[0] = r_match;
                    rdata[1] = (r_state == ST_RUN);
                end
                default:     rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mmio_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32i_mmio_timer
//  Description : Cycle-by-cycle vector bench for rv32i_mmio_timer. Each
//                vector drives one bus cycle and states the expected
//                combinational read-back for that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_mmio_timer;

    localparam logic [31:0] c_base = 32'hFFFF_0100;
    localparam logic [31:0] c_ctrl = c_base;
    localparam logic [31:0] c_cnt  = c_base + 32'h4;
    localparam logic [31:0] c_cmp  = c_base + 32'h8;
    localparam logic [31:0] c_stat = c_base + 32'hC;
    localparam int          c_timeout_cycles = 2000;
`ifdef TIMER_IRQ_EN
    localparam logic c_ie = 1'b1;
`else
    localparam logic c_ie = 1'b0;
`endif

    typedef struct packed {
        logic        rst;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp_rdata;
        logic        exp_irq;
    } vec_t;

    typedef struct packed {
        logic        sel;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwdata;
    logic        sel;
    logic [31:0] rdata;
    logic        irq;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_vec;
    int   n_chk;
    int   n_err;
    logic done;

    rv32i_mmio_timer #(
        .BASE_ADDR  (32'hFFFF_0100),
        .PRESCALE_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .memaddr  (memaddr),
        .memwdata (memwdata),
        .sel      (sel),
        .rdata    (rdata),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic chk,
                                input logic [31:0] erd, input logic eirq);
        vec_t v;
        v.rst = rst; v.we = we; v.addr = addr; v.wdata = wd;
        v.chk = chk; v.exp_rdata = erd; v.exp_irq = eirq;
        vecs.push_back(v);
    endfunction

    function automatic void rd(input logic [31:0] addr, input logic [31:0] erd, input logic eirq);
        add(1'b0, 1'b0, addr, 32'd0, 1'b1, erd, eirq);
    endfunction

    function automatic void wr(input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] erd, input logic eirq);
        add(1'b0, 1'b1, addr, wd, 1'b1, erd, eirq);
    endfunction

    initial begin : g_watchdog
        repeat (c_timeout_cycles) @(posedge clk);
        if (!done) begin
            $display("FAIL: timeout after %0d cycles, %0d vectors compared", c_timeout_cycles, n_vec);
            $finish;
        end
    end

    initial begin
        exp_t e;
        exp_t got;
        done     = 1'b0;
        n_vec    = 0;
        n_chk    = 0;
        n_err    = 0;
        reset    = 1'b1;
        memwrite = 1'b0;
        memaddr  = 32'd0;
        memwdata = 32'd0;

        // Reset values and address decode
        add(1'b1, 1'b0, c_ctrl, 32'd0, 1'b0, 32'd0, 1'b0);
        add(1'b1, 1'b0, c_ctrl, 32'd0, 1'b0, 32'd0, 1'b0);
        rd(c_ctrl, 32'd0, 1'b0);
        rd(c_cnt,  32'd0, 1'b0);
        rd(c_cmp,  32'hFFFF_FFFF, 1'b0);
        rd(c_stat, 32'd0, 1'b0);
        rd(c_base + 32'h10, 32'd0, 1'b0);
        rd(c_base + 32'h2,  32'd0, 1'b0);

        // Periodic, PRE=0: COUNT 0,1,2,3,0 then MATCH; W1C collides with next match
        wr(c_cmp,  32'd3, 32'hFFFF_FFFF, 1'b0);
        wr(c_ctrl, 32'h1, 32'd0, 1'b0);
        for (int i = 0; i < 4; i++) rd(c_cnt, 32'(i), 1'b0);
        rd(c_cnt,  32'd0, 1'b0);
        rd(c_stat, 32'h3, 1'b0);
        rd(c_stat, 32'h3, 1'b0);
        wr(c_stat, 32'h1, 32'h3, 1'b0);
        rd(c_stat, 32'h3, 1'b0);
        wr(c_stat, 32'h1, 32'h3, 1'b0);
        wr(c_ctrl, 32'h0, 32'h1, 1'b0);
        rd(c_stat, 32'h0, 1'b0);
        rd(c_cnt,  32'd3, 1'b0);

        // COUNT write in a tick cycle wins over the increment
        wr(c_cmp,  32'h1000, 32'd3, 1'b0);
        wr(c_ctrl, 32'h1, 32'd0, 1'b0);
        wr(c_cnt,  32'h100, 32'd3, 1'b0);
        rd(c_cnt,  32'h100, 1'b0);
        rd(c_cnt,  32'h101, 1'b0);
        wr(c_ctrl, 32'h0, 32'h1, 1'b0);
        rd(c_cnt,  32'h103, 1'b0);

        // One-shot, PRE=3: COUNT steps every 4 cycles and stops at CMP
        wr(c_cnt,  32'd0, 32'h103, 1'b0);
        wr(c_cmp,  32'd2, 32'h1000, 1'b0);
        wr(c_ctrl, 32'h303, 32'd0, 1'b0);
        for (int i = 0; i < 12; i++) rd(c_cnt, 32'(i / 4), 1'b0);
        rd(c_ctrl, 32'h302, 1'b0);
        rd(c_stat, 32'h1, 1'b0);
        rd(c_cnt,  32'd2, 1'b0);
        rd(c_cnt,  32'd2, 1'b0);
        wr(c_stat, 32'h1, 32'h1, 1'b0);
        rd(c_stat, 32'h0, 1'b0);

        // Reset asserted mid-run at COUNT=5
        wr(c_cnt,  32'd0, 32'd2, 1'b0);
        wr(c_cmp,  32'd7, 32'd2, 1'b0);
        wr(c_ctrl, 32'h5, 32'h302, 1'b0);
        for (int i = 0; i < 5; i++) rd(c_cnt, 32'(i), 1'b0);
        add(1'b1, 1'b0, c_cnt, 32'd0, 1'b1, 32'd5, 1'b0);
        rd(c_cnt,  32'd0, 1'b0);
        rd(c_stat, 32'd0, 1'b0);
        rd(c_cmp,  32'hFFFF_FFFF, 1'b0);
        rd(c_ctrl, 32'd0, 1'b0);

        // Interrupt follows MATCH & IE until cleared
        wr(c_cmp,  32'd1, 32'hFFFF_FFFF, 1'b0);
        wr(c_ctrl, 32'h5, 32'd0, 1'b0);
        rd(c_cnt,  32'd0, 1'b0);
        rd(c_cnt,  32'd1, 1'b0);
        rd(c_stat, 32'h3, c_ie);
        wr(c_ctrl, 32'h4, {29'd0, c_ie, 2'b01}, c_ie);
        rd(c_stat, 32'h1, c_ie);
        wr(c_stat, 32'h1, 32'h1, c_ie);
        rd(c_stat, 32'h0, 1'b0);
        rd(c_ctrl, {29'd0, c_ie, 2'b00}, 1'b0);

        // Apply: drive on the falling edge, check 1ns later, commit on the rising edge
        foreach (vecs[k]) begin
            @(negedge clk);
            reset    = vecs[k].rst;
            memwrite = vecs[k].we;
            memaddr  = vecs[k].addr;
            memwdata = vecs[k].wdata;
            if (vecs[k].chk) begin
                n_chk++;
                e.sel   = (vecs[k].addr[31:4] == c_base[31:4]);
                e.rdata = vecs[k].exp_rdata;
                e.irq   = vecs[k].exp_irq;
                sb.push_back(e);
            end
            #1;
            if (vecs[k].rst && !vecs[k].chk) begin
                if ((irq !== 1'b0) || (sel !== (vecs[k].addr[31:4] == c_base[31:4]))) begin
                    n_err++;
                    $display("FAIL vec%0d reset-state: sel=%b irq=%b", k, sel, irq);
                end
            end
            if (vecs[k].chk) begin
                e         = sb.pop_front();
                got.sel   = sel;
                got.rdata = rdata;
                got.irq   = irq;
                n_vec++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL vec%0d addr=%h: got sel=%b rdata=%h irq=%b, want sel=%b rdata=%h irq=%b",
                             k, vecs[k].addr, got.sel, got.rdata, got.irq, e.sel, e.rdata, e.irq);
                end
            end
        end

        @(negedge clk);
        memwrite = 1'b0;
        if ((sb.size() != 0) || (n_vec != n_chk)) begin
            n_err++;
            $display("FAIL: scoreboard not drained (%0d left), compared %0d of %0d",
                     sb.size(), n_vec, n_chk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err != 0) begin
            $display("FAIL: %0d miscompares", n_err);
        end else begin
            $display("PASS");
        end
        done = 1'b1;
        $finish;
    end

endmodule
`default_nettype wire
